fibo_datapath: RTL and testbench

Parameterised datapath for the Fibonacci engine: a 4-entry register file with two asynchronous read ports, an 8-operation ALU, and a write-back mux. The mux selects between an external seed value (count) and the ALU result. Driven cycle-by-cycle by the Fibonacci controller FSM, which supplies addresses, opcode, write enable and load select. The write-back value and ALU zero status are returned to the controller/outputs.

---
 rtl/fibo_datapath_if.sv | 27 ++
 rtl/fibo_datapath.sv | 69 ++++++
 tb/tb_fibo_datapath.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fibo_datapath_if.sv
// Controller-to-datapath bus for the Fibonacci engine: register file
// addressing, ALU opcode, write-back select and the returned status/data.
interface fibo_datapath_if #(
  parameter int unsigned size = 4
);
  logic [size-3:0] wrt_addr;
  logic            wrt_en;
  logic            load_data;
  logic [size-3:0] rd_addr1;
  logic [size-3:0] rd_addr2;
  logic [size-2:0] alu_opcode;
  logic [size-1:0] count;
  logic            zero_flag;
  logic [size-1:0] data;

  // Controller side: drives control and seed, observes write-back and status.
  modport master (
    output wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2, alu_opcode, count,
    input  zero_flag, data
  );

  // Datapath side.
  modport slave (
    input  wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2, alu_opcode, count,
    output zero_flag, data
  );
endinterface

// File: rtl/fibo_datapath.sv
// Fibonacci engine datapath: 2^(size-2)-entry register file with two
// asynchronous read ports, an 8-operation ALU and a write-back mux that picks
// either the external seed (count) or the ALU result.
module fibo_datapath #(
  parameter int unsigned size = 4
) (
  input logic           clk,
  input logic           rst,
  fibo_datapath_if.slave bus
);

  localparam int unsigned addr_w = size - 2;
  localparam int unsigned op_w   = size - 1;
  localparam int unsigned depth  = 1 << addr_w;

  localparam logic [op_w-1:0] op_pass_a = op_w'(0);
  localparam logic [op_w-1:0] op_pass_b = op_w'(1);
  localparam logic [op_w-1:0] op_and    = op_w'(2);
  localparam logic [op_w-1:0] op_or     = op_w'(3);
  localparam logic [op_w-1:0] op_xor    = op_w'(4);
  localparam logic [op_w-1:0] op_sub    = op_w'(5);
  localparam logic [op_w-1:0] op_add    = op_w'(6);
  localparam logic [op_w-1:0] op_inc    = op_w'(7);

  logic [size-1:0] regs [depth];
  logic [size-1:0] opnd_a;
  logic [size-1:0] opnd_b;
  logic [size-1:0] alu_result;
  logic [size-1:0] wb_data;

  // Asynchronous reads; a write lands only at the edge, so there is no bypass.
  assign opnd_a = regs[bus.rd_addr1];
  assign opnd_b = regs[bus.rd_addr2];

  // ALU: all arithmetic wraps modulo 2^size, carry/borrow dropped.
  always_comb begin
    alu_result = '0;
    case (bus.alu_opcode)
      op_pass_a: alu_result = opnd_a;
      op_pass_b: alu_result = opnd_b;
      op_and:    alu_result = opnd_a & opnd_b;
      op_or:     alu_result = opnd_a | opnd_b;
      op_xor:    alu_result = opnd_a ^ opnd_b;
      op_sub:    alu_result = opnd_a - opnd_b;
      op_add:    alu_result = opnd_a + opnd_b;
      op_inc:    alu_result = opnd_a + size'(1);
      default:   alu_result = '0;
    endcase
  end

  // Write-back mux; the same value is exported and written to the register file.
  always_comb begin
    wb_data = bus.load_data ? bus.count : alu_result;
  end

  assign bus.data      = wb_data;
  // Status reflects the ALU alone, independent of the write-back select.
  assign bus.zero_flag = (alu_result == '0);

  // Register file update; reset takes priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (bus.wrt_en) begin
      regs[bus.wrt_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_fibo_datapath.sv
// Directed bench for fibo_datapath: each step drives the bus between clock
// edges, queues the expected write-back/zero values and checks them before
// the next rising edge commits the write.
module tb_fibo_datapath;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    string      tag;
    logic [3:0] d;
    logic       z;
  } exp_t;

  exp_t sb_q[$];

  fibo_datapath_if #(.size(4)) bus ();

  fibo_datapath #(.size(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue required one entry");
    end else begin
      e = sb_q.pop_front();
      checks++;
      assert (bus.data === e.d) else begin
        errors++;
        $error("FAIL %s data: got %0d required %0d", e.tag, bus.data, e.d);
      end
      checks++;
      assert (bus.zero_flag === e.z) else begin
        errors++;
        $error("FAIL %s zero_flag: got %0b required %0b", e.tag, bus.zero_flag, e.z);
      end
    end
  endtask

  // Drive one cycle's controls after the falling edge, queue the expectation,
  // then sample the combinational outputs well before the next rising edge.
  task automatic apply(input string tag, input logic r, input logic [1:0] wa, input logic we,
                       input logic ld, input logic [1:0] r1, input logic [1:0] r2,
                       input logic [2:0] op, input logic [3:0] cnt,
                       input logic [3:0] exp_d, input logic exp_z);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.wrt_addr   = wa;
    bus.wrt_en     = we;
    bus.load_data  = ld;
    bus.rd_addr1   = r1;
    bus.rd_addr2   = r2;
    bus.alu_opcode = op;
    bus.count      = cnt;
    e.tag = tag;
    e.d   = exp_d;
    e.z   = exp_z;
    sb_q.push_back(e);
    #1;
    check_out();
  endtask

  localparam logic [3:0] fib_exp [12] = '{4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5,
                                          4'd2, 4'd7, 4'd9, 4'd0, 4'd9, 4'd9};
  localparam logic [3:0] sweep_exp [8] = '{4'd12, 4'd5, 4'd4, 4'd13, 4'd9, 4'd7, 4'd1, 4'd13};
  localparam logic [3:0] gate_exp [4] = '{4'd9, 4'd9, 4'd0, 4'd9};

  initial begin
    logic [1:0] wa;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [3:0] ed;
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.wrt_addr   = '0;
    bus.wrt_en     = 1'b0;
    bus.load_data  = 1'b0;
    bus.rd_addr1   = '0;
    bus.rd_addr2   = '0;
    bus.alu_opcode = 3'b110;
    bus.count      = '0;
    repeat (2) @(posedge clk);

    // Arbitrary writes of 9 everywhere, reads of entry 3 see the old value.
    for (int k = 0; k < 4; k++) begin
      wa = 2'(k);
      apply($sformatf("prewr%0d", k), 1'b0, wa, 1'b1, 1'b1, 2'd3, 2'd3, 3'b110, 4'd9,
            4'd9, 1'b1);
    end
    // Reset with a simultaneous write: R3+R3 = 18 wraps to 2.
    apply("rst_wr", 1'b1, 2'd2, 1'b1, 1'b1, 2'd3, 2'd3, 3'b110, 4'd6, 4'd6, 1'b0);

    // Every read pair after reset adds to zero.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        r1 = 2'(a);
        r2 = 2'(b);
        apply($sformatf("rst_rd%0d%0d", a, b), 1'b0, 2'd0, 1'b0, 1'b0, r1, r2, 3'b110, 4'd0,
              4'd0, 1'b1);
      end
    end

    // Seed load: operand B reads the pre-write value of the target entry.
    for (int k = 0; k < 4; k++) begin
      wa = 2'(k);
      apply($sformatf("seed%0d", k), 1'b0, wa, 1'b1, 1'b1, wa, wa, 3'b001, 4'd1, 4'd1, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      r2 = 2'(k);
      apply($sformatf("seed_rd%0d", k), 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, r2, 3'b001, 4'd0,
            4'd1, 1'b0);
    end

    // Fibonacci chain rotating through the four registers.
    for (int s = 0; s < 12; s++) begin
      wa = 2'((s + 1) % 4);
      r1 = 2'(s % 4);
      r2 = 2'((s + 3) % 4);
      ed = fib_exp[s];
      apply($sformatf("fib%0d", s), 1'b0, wa, 1'b1, 1'b0, r1, r2, 3'b110, 4'd0, ed,
            (ed == 4'd0));
    end

    // Write enable low: count still visible on data, registers untouched.
    apply("gate", 1'b0, 2'd1, 1'b0, 1'b1, 2'd0, 2'd2, 3'b110, 4'd15, 4'd15, 1'b0);
    for (int k = 0; k < 4; k++) begin
      r1 = 2'(k);
      ed = gate_exp[k];
      apply($sformatf("gate_rd%0d", k), 1'b0, 2'd0, 1'b0, 1'b0, r1, 2'd0, 3'b000, 4'd0, ed,
            (ed == 4'd0));
    end

    // Opcode sweep with A=12 (R0) and B=5 (R1).
    apply("ld12", 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 2'd1, 3'b000, 4'd12, 4'd12, 1'b0);
    apply("ld5", 1'b0, 2'd1, 1'b1, 1'b1, 2'd0, 2'd1, 3'b000, 4'd5, 4'd5, 1'b0);
    for (int o = 0; o < 8; o++) begin
      apply($sformatf("op%0d", o), 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd1, 3'(o), 4'd0,
            sweep_exp[o], 1'b0);
    end
    apply("sub_eq", 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 3'b101, 4'd0, 4'd0, 1'b1);
    // zero_flag ignores the write-back select.
    apply("zf_ld", 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 2'd1, 3'b101, 4'd7, 4'd7, 1'b1);

    // Underflow: R2=0 minus R3=1 wraps to all ones.
    apply("ld1", 1'b0, 2'd3, 1'b1, 1'b1, 2'd2, 2'd3, 3'b101, 4'd1, 4'd1, 1'b0);
    apply("under", 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 2'd3, 3'b101, 4'd0, 4'd15, 1'b0);

    // Reset beats a same-edge write to R1.
    apply("rstpri", 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 2'd1, 3'b000, 4'd10, 4'd10, 1'b0);
    apply("rstpri_rd", 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 3'b000, 4'd0, 4'd0, 1'b1);
    apply("inc0", 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd1, 3'b111, 4'd0, 4'd1, 1'b0);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty: got %0d entries required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
